// File: rtl/rt_gray_cnt_pkg.sv
// rt_gray_pkg: shared helpers for the rt_gray_cnt counter family.
//   f_bin2gray / f_gray2bin : width-generic conversions on a 64-bit carrier.
//                             The caller passes the real width and casts the
//                             result back down.
//   LP_MODE_WRAP / LP_MODE_SAT : encodings for PARAM_SAT_MODE.
package rt_gray_pkg;

  localparam int LP_MODE_WRAP = 0;
  localparam int LP_MODE_SAT  = 1;
  localparam int LP_MAX_W     = 64;

  function automatic logic [LP_MAX_W-1:0] f_width_mask(input int unsigned w);
    logic [LP_MAX_W-1:0] mask;
    if (w >= LP_MAX_W) mask = '1;
    else               mask = (64'd1 << w) - 64'd1;
    return mask;
  endfunction

  function automatic logic [LP_MAX_W-1:0] f_bin2gray(input logic [LP_MAX_W-1:0] bin,
                                                      input int unsigned         w);
    return (bin ^ (bin >> 1)) & f_width_mask(w);
  endfunction

  // Prefix XOR from the MSB down. Bits above w are masked to zero first so
  // they cannot leak into the result.
  function automatic logic [LP_MAX_W-1:0] f_gray2bin(input logic [LP_MAX_W-1:0] gray,
                                                      input int unsigned         w);
    logic [LP_MAX_W-1:0] g;
    logic [LP_MAX_W-1:0] b;
    g = gray & f_width_mask(w);
    b = '0;
    b[LP_MAX_W-1] = g[LP_MAX_W-1];
    for (int i = LP_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rt_gray_cnt_step_chk.sv
// rt_gray_step_chk: sticky Gray-step error flag.
//   clk      in  1  clock, rising edge
//   rst_n    in  1  async active-low reset, clears err
//   clr      in  1  sync clear of err, active-high
//   chk_en   in  1  this cycle is a unit step that moves the count
//   gray_cur in  N  Gray value currently registered
//   gray_nxt in  N  Gray value about to be registered
//   err      out 1  set once a checked step changes anything other than one bit
module rt_gray_step_chk #(
  parameter int PARAM_BIT_NUM = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     chk_en,
  input  logic [PARAM_BIT_NUM-1:0] gray_cur,
  input  logic [PARAM_BIT_NUM-1:0] gray_nxt,
  output logic                     err
);

  logic bad_p0;
  logic err_p1;

  assign bad_p0 = chk_en && ($countones(gray_cur ^ gray_nxt) != 1);

  // ---- stage p0 -> p1: sticky flag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p1 <= 1'b0;
    end else if (clr) begin
      err_p1 <= 1'b0;
    end else if (bad_p0) begin
      err_p1 <= 1'b1;
    end
  end

  assign err = err_p1;

endmodule

// File: rtl/rt_gray_cnt.sv
// rt_gray_cnt: up/down counter with registered binary and Gray outputs.
// The Gray output is driven directly from flops, so it is safe to hand
// across clock domains.
//   rt_i_clk       in  1  clock, rising edge
//   rt_i_rst_n     in  1  async active-low reset
//   rt_i_rst       in  1  sync reset, active-high (highest priority)
//   rt_i_set       in  1  sync load of rt_i_ld_val
//   rt_i_ce        in  1  count enable
//   rt_i_inc_n     in  1  0 = count up, 1 = count down
//   rt_i_step_big  in  1  0 = step 1, 1 = step 2
//   rt_i_ld_val    in  N  binary load value
//   rt_o_bin_cnt   out N  registered binary count
//   rt_o_gray_cnt  out N  registered Gray count of rt_o_bin_cnt
//   rt_o_eqnz      out 1  registered, count != 0
//   rt_o_evt       out 1  one-cycle pulse on wrap (wrap mode) or a blocked step (saturate mode)
//   rt_o_err       out 1  sticky Gray-step error
module rt_gray_cnt
  import rt_gray_pkg::*;
#(
  parameter int                     PARAM_BIT_NUM  = 32,
  parameter int                     PARAM_SAT_MODE = LP_MODE_WRAP,
  parameter logic [PARAM_BIT_NUM-1:0] PARAM_RST_VAL = '0
) (
  input  logic                     rt_i_clk,
  input  logic                     rt_i_rst_n,
  input  logic                     rt_i_rst,
  input  logic                     rt_i_set,
  input  logic                     rt_i_ce,
  input  logic                     rt_i_inc_n,
  input  logic                     rt_i_step_big,
  input  logic [PARAM_BIT_NUM-1:0] rt_i_ld_val,
  output logic [PARAM_BIT_NUM-1:0] rt_o_bin_cnt,
  output logic [PARAM_BIT_NUM-1:0] rt_o_gray_cnt,
  output logic                     rt_o_eqnz,
  output logic                     rt_o_evt,
  output logic                     rt_o_err
);

  localparam int             N        = PARAM_BIT_NUM;
  localparam logic [N-1:0]   MAX_VAL  = '1;
  localparam logic [N-1:0]   RST_GRAY = N'(f_bin2gray(64'(PARAM_RST_VAL), N));
  localparam logic           SAT_ON   = (PARAM_SAT_MODE == LP_MODE_SAT);

  // Returns {evt, next}. The sum is held in N+2 signed bits so that both an
  // underflow (negative) and an overflow (bit N set) are visible without the
  // carry being lost.
  function automatic logic [N:0] f_step(input logic [N-1:0] cur,
                                        input logic         dn,
                                        input logic         big,
                                        input logic         sat);
    logic signed [N+1:0] stp;
    logic signed [N+1:0] sum;
    logic                under;
    logic                over;
    logic [N-1:0]        nxt;
    stp   = big ? (N+2)'(2) : (N+2)'(1);
    sum   = signed'({2'b00, cur}) + (dn ? -stp : stp);
    under = sum[N+1];
    over  = !sum[N+1] && sum[N];
    if (sat && under)     nxt = '0;
    else if (sat && over) nxt = MAX_VAL;
    else                  nxt = sum[N-1:0];
    return {under || over, nxt};
  endfunction

  logic [N-1:0] bin_p0;
  logic [N-1:0] gray_p0;
  logic         eqnz_p0;
  logic         evt_p0;
  logic         chk_en_p0;
  logic [N-1:0] step_bin_p0;
  logic         step_evt_p0;

  logic [N-1:0] bin_p1;
  logic [N-1:0] gray_p1;
  logic         eqnz_p1;
  logic         evt_p1;

  // ---- stage p0: next-state selection ----
  assign {step_evt_p0, step_bin_p0} = f_step(bin_p1, rt_i_inc_n, rt_i_step_big, SAT_ON);

  always_comb begin
    bin_p0    = bin_p1;
    evt_p0    = 1'b0;
    chk_en_p0 = 1'b0;
    if (rt_i_rst) begin
      bin_p0 = PARAM_RST_VAL;
    end else if (rt_i_set) begin
      bin_p0 = rt_i_ld_val;
    end else if (rt_i_ce) begin
      bin_p0    = step_bin_p0;
      evt_p0    = step_evt_p0;
      // Only unit steps that actually move the count should flip exactly one bit.
      chk_en_p0 = !rt_i_step_big && (step_bin_p0 != bin_p1);
    end
  end

  // Continuous assignment keeps the Gray value derived from the selected binary value.
  assign gray_p0 = N'(f_bin2gray(64'(bin_p0), N));
  assign eqnz_p0 = |bin_p0;

  // ---- stage p0 -> p1: output registers ----
  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      bin_p1  <= PARAM_RST_VAL;
      gray_p1 <= RST_GRAY;
      eqnz_p1 <= |PARAM_RST_VAL;
      evt_p1  <= 1'b0;
    end else begin
      bin_p1  <= bin_p0;
      gray_p1 <= gray_p0;
      eqnz_p1 <= eqnz_p0;
      evt_p1  <= evt_p0;
    end
  end

  rt_gray_step_chk #(
    .PARAM_BIT_NUM(N)
  ) u_chk (
    .clk      (rt_i_clk),
    .rst_n    (rt_i_rst_n),
    .clr      (rt_i_rst),
    .chk_en   (chk_en_p0),
    .gray_cur (gray_p1),
    .gray_nxt (gray_p0),
    .err      (rt_o_err)
  );

  assign rt_o_bin_cnt  = bin_p1;
  assign rt_o_gray_cnt = gray_p1;
  assign rt_o_eqnz     = eqnz_p1;
  assign rt_o_evt      = evt_p1;

endmodule
